// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and types.
// Derived constants are pre-sized to the 10-bit coordinate type.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;

  localparam coord_t H_VIS        = coord_t'(H_ACTIVE);
  localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);

  localparam coord_t V_VIS        = coord_t'(V_ACTIVE);
  localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register aligning {hs, vs, blank} with a pipelined renderer.
// DEPTH 0 is a plain wire-through.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  vga_clk,
  input  logic  reset_n,
  input  sync_t d,
  output sync_t q
);

  generate
    if (DEPTH == 0) begin : g_thru
      assign q = d;
    end else begin : g_pipe
      sync_t stage [DEPTH];

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
        end else begin
          stage[0] <= d;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: pixel/line counters, registered sync/blank decodes,
// optional sync delay line, frame-start pulse and frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  coord_t x_nxt;
  coord_t y_nxt;
  sync_t  dec_nxt;
  sync_t  dec_q;
  sync_t  dec_dly;
  logic   fs_nxt;

  // Decodes use the next-counter values so the registered result lines up
  // with DrawX/DrawY in the same cycle.
  always_comb begin
    x_nxt = (DrawX == H_LAST) ? '0 : DrawX + 10'd1;
    y_nxt = DrawY;
    if (DrawX == H_LAST) y_nxt = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;

    dec_nxt.hs    = !((x_nxt >= H_SYNC_START) && (x_nxt <= H_SYNC_END));
    dec_nxt.vs    = !((y_nxt >= V_SYNC_START) && (y_nxt <= V_SYNC_END));
    dec_nxt.blank = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    fs_nxt        = (x_nxt == '0) && (y_nxt == '0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      dec_q       <= SYNC_IDLE;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      dec_q       <= dec_nxt;
      frame_start <= fs_nxt;
      if (fs_nxt) frame_count <= frame_count + 8'd1;
    end
  end

  vga_sync_delay #(
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       (dec_q),
    .q       (dec_dly)
  );

  assign hs    = dec_dly.hs;
  assign vs    = dec_dly.vs;
  assign blank = dec_dly.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (SYNC_DELAY 0/1/4) checked every
// cycle against a linear pixel-index model; counter jumps reach distant lines.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] dx [3];
  logic [9:0] dy [3];
  logic       hs_o [3];
  logic       vs_o [3];
  logic       bl_o [3];
  logic       fs_o [3];
  logic [7:0] fc_o [3];

  int n_checks = 0;
  int n_errors = 0;
  int dly [3] = '{0, 1, 4};

  always #5 clk = ~clk;

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[0]), .DrawY(dy[0]),
    .hs(hs_o[0]), .vs(vs_o[0]), .blank(bl_o[0]),
    .frame_start(fs_o[0]), .frame_count(fc_o[0]));

  vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[1]), .DrawY(dy[1]),
    .hs(hs_o[1]), .vs(vs_o[1]), .blank(bl_o[1]),
    .frame_start(fs_o[1]), .frame_count(fc_o[1]));

  vga_timing_gen #(.SYNC_DELAY(4)) u_d4 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[2]), .DrawY(dy[2]),
    .hs(hs_o[2]), .vs(vs_o[2]), .blank(bl_o[2]),
    .frame_start(fs_o[2]), .frame_count(fc_o[2]));

  // Reference model: pos is the pixel index within the frame (-1 while in
  // reset); history index i is the undelayed decode from i cycles ago.
  int pos;
  int m_fc;
  bit m_fs;
  bit h_h [5];
  bit v_h [5];
  bit b_h [5];

  int    run      [3][3];
  bit    valid    [3][3];
  bit    prev_act [3][3];
  int    start_x  [3] = '{656, 0, 0};
  int    width    [3] = '{96, 1600, 640};
  string sname    [3] = '{"hs", "vs", "blank"};

  logic [9:0] jx, jy;
  logic [7:0] jfc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void decode(input int p, output bit h, output bit v, output bit b);
    int x, y;
    x = p % 800;
    y = p / 800;
    h = !(x >= 656 && x <= 751);
    v = !(y >= 490 && y <= 491);
    b = (x < 640) && (y < 480);
  endfunction

  task automatic model_reset();
    pos  = -1;
    m_fc = 0;
    m_fs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      h_h[i] = 1'b1;
      v_h[i] = 1'b1;
      b_h[i] = 1'b0;
    end
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 3; s++) valid[k][s] = 1'b0;
  endtask

  task automatic advance();
    pos = (pos < 0) ? 0 : (pos + 1) % 420000;
    for (int i = 4; i > 0; i--) begin
      h_h[i] = h_h[i-1];
      v_h[i] = v_h[i-1];
      b_h[i] = b_h[i-1];
    end
    decode(pos, h_h[0], v_h[0], b_h[0]);
    m_fs = (pos == 0);
    if (m_fs) m_fc = (m_fc + 1) % 256;
  endtask

  // Pulse shape: start column and contiguous width of each active run.
  task automatic track(input int k, input int s, input bit act);
    if (act && !prev_act[k][s]) begin
      run[k][s]   = 1;
      valid[k][s] = 1'b1;
      chk($sformatf("d%0d_%s_start_x", dly[k], sname[s]), dx[k], start_x[s] + dly[k]);
    end else if (act) begin
      run[k][s]++;
    end else if (prev_act[k][s] && valid[k][s]) begin
      chk($sformatf("d%0d_%s_width", dly[k], sname[s]), run[k][s], width[s]);
      valid[k][s] = 1'b0;
    end
    prev_act[k][s] = act;
  endtask

  task automatic check_all();
    int ex, ey, d;
    ex = (pos < 0) ? 799 : pos % 800;
    ey = (pos < 0) ? 524 : pos / 800;
    for (int k = 0; k < 3; k++) begin
      d = dly[k];
      chk($sformatf("d%0d_DrawX", d), dx[k], ex);
      chk($sformatf("d%0d_DrawY", d), dy[k], ey);
      chk($sformatf("d%0d_hs", d), hs_o[k], h_h[d]);
      chk($sformatf("d%0d_vs", d), vs_o[k], v_h[d]);
      chk($sformatf("d%0d_blank", d), bl_o[k], b_h[d]);
      chk($sformatf("d%0d_frame_start", d), fs_o[k], m_fs);
      chk($sformatf("d%0d_frame_count", d), fc_o[k], m_fc);
      track(k, 0, hs_o[k] == 1'b0);
      track(k, 1, vs_o[k] == 1'b0);
      track(k, 2, bl_o[k] == 1'b1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) advance();
    @(negedge clk);
    check_all();
  endtask

  task automatic goto_x780();
    for (int i = 0; i < 800 && (pos % 800) != 780; i++) step();
  endtask

  task automatic goto_pos(input int target);
    for (int i = 0; i < 2000 && pos != target; i++) step();
  endtask

  // Called at x=780 where hs/vs/blank are idle; targets are idle columns too,
  // so the delay-line history stays valid across the jump.
  task automatic jump(input int target, input int fc_new);
    jx  = 10'(target % 800);
    jy  = 10'(target / 800);
    jfc = 8'((fc_new < 0) ? m_fc : fc_new);
    force u_d0.DrawX = jx; force u_d0.DrawY = jy; force u_d0.frame_count = jfc;
    force u_d1.DrawX = jx; force u_d1.DrawY = jy; force u_d1.frame_count = jfc;
    force u_d4.DrawX = jx; force u_d4.DrawY = jy; force u_d4.frame_count = jfc;
    #1;
    release u_d0.DrawX; release u_d0.DrawY; release u_d0.frame_count;
    release u_d1.DrawX; release u_d1.DrawY; release u_d1.frame_count;
    release u_d4.DrawX; release u_d4.DrawY; release u_d4.frame_count;
    pos = target;
    if (fc_new >= 0) m_fc = fc_new;
  endtask

  initial begin
    reset_n = 1'b1;
    model_reset();
    #3 reset_n = 1'b0;
    #1 check_all();
    repeat (3) step();
    reset_n = 1'b1;

    repeat ($urandom_range(1700, 2600)) step();

    goto_x780();
    jump(488 * 800 + 799, -1);
    repeat (3300) step();

    goto_x780();
    jump(524 * 800 + 799, 255);
    repeat ($urandom_range(900, 1800)) step();

    goto_x780();
    jump(489 * 800 + 799, -1);
    goto_pos(490 * 800 + 700);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat ($urandom_range(2, 8)) step();
    reset_n = 1'b1;

    repeat ($urandom_range(1700, 2500)) step();
    #($urandom_range(1, 3)) reset_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat ($urandom_range(1, 6)) step();
    reset_n = 1'b1;
    repeat (900) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
